pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer for the processor core. It owns the PC,
//  next-PC selection (seq/branch/jump/jr), halt and I/O-wait stalls with confirm
//  edge detection, and a retired-instruction counter. It sits between the control
//  unit and the instruction memory; the ULA supplies the branch zero flag.
// PARAMETERS
//  PC_W       32   PC and target width (bits)
//  IMEM_DEPTH 64   valid instruction words; must satisfy 1 <= IMEM_DEPTH <= 2**PC_W
//  CNT_W      32   retired-instruction counter width
//  RESET_PC   0    PC value after reset
// PORTS
//  clock       in   1      system clock (divided core clock)
//  reset       in   1      synchronous, active-high
//  branch      in   1      instruction is a conditional branch
//  zero        in   1      ULA branch condition
//  jump        in   1      unconditional jump
//  jr          in   1      jump target comes from reg_target (needs jump=1)
//  hlt         in   1      halt instruction
//  io_wait     in   1      instruction waits for operator confirm (stall)
//  confirm     in   1      debounced confirm level
//  imm         in   PC_W   sign-extended immediate / absolute target
//  reg_target  in   PC_W   register value for jr
//  pc          out  PC_W   current PC (instruction memory address)
//  pc_plus_one out  PC_W   pc+1, for $ra write-back
//  retire      out  1      current instruction completes this cycle
//  halted      out  1      FSM is in HALT
//  fault       out  1      FSM is in FAULT (PC_BOUND_CHECK_EN only, else 0)
//  instret     out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=RUN, instret=0, halted=0, fault=0, conf_q=0.
//    Reset wins over every other input in the same cycle, in any state.
//  - Confirm edge: conf_q <= confirm each cycle; conf_rise = confirm & ~conf_q.
//  - Next PC (priority high->low): branch&zero -> pc+1+imm; jump&jr -> reg_target;
//    jump -> imm; else pc+1. All sums modulo 2**PC_W; carry out discarded.
//  - FSM states RUN, WAIT, HALT, FAULT:
//    RUN:  hlt -> HALT, pc held, retire=1 (hlt counts once). hlt has priority over io_wait.
//          io_wait & ~conf_rise -> WAIT, pc held, retire=0.
//          io_wait & conf_rise -> stay RUN, pc<=next, retire=1.
//          otherwise pc<=next, retire=1.
//    WAIT: pc held. conf_rise -> RUN, pc<=next, retire=1. A confirm level already high
//          on WAIT entry does not release; a fresh rising edge is required.
//    HALT: pc, instret frozen; exit only by reset. halted=1 (registered, from the cycle after hlt).
//    FAULT: as HALT, with fault=1.
//  - retire is combinational from state+inputs; instret<=instret+retire, wraps at 2**CNT_W.
//  - pc_plus_one is combinational pc+1 and is valid in every state.
//  - Inputs are sampled only in RUN/WAIT; in HALT/FAULT they are ignored.
// CONFIGURATION
//  PC_BOUND_CHECK_EN defined: a next-PC target >= IMEM_DEPTH (including pc+1 off the end)
//    is not loaded; instead FSM -> FAULT, pc holds the faulting instruction's address,
//    retire=0 for it.
//  Not defined: there is no check; target truncated to PC_W; addresses beyond
//    IMEM_DEPTH are the memory's concern; the FAULT state is absent; fault tied 0.
// STRUCTURE
//  Shared package pc_seq_pkg: state encoding localparams (RUN=2'd0, WAIT=2'd1,
//  HALT=2'd2, FAULT=2'd3), next-PC select codes (SEQ, BR, JMP, JR).
//  One sub-module: pc_next_sel (combinational target mux + bound compare);
//  FSM, conf_q, pc and instret registers are in pc_sequencer.
// TESTING
//  1 reset; 5 cycles, no control -> pc 0,1,2,3,4; instret=5; retire=1 throughout.
//  2 pc=10, branch=1,zero=1,imm=-3 -> pc=8; zero=0 -> pc=11; branch&zero&jump,imm=-3 -> branch wins.
//  3 pc=4, jump=1,jr=1,reg_target=20 -> pc=20; jr=0,imm=7 -> pc=7; pc_plus_one=pc+1 every cycle.
//  4 io_wait=1 with confirm held high -> WAIT, pc stays for 6 cycles; confirm low then high ->
//    pc advances exactly once; instret increments once.
//  5 hlt at pc=9 -> halted=1 next cycle, pc=9 frozen for 10 cycles; reset asserted while
//    halted -> pc=RESET_PC, instret=0, halted=0.
//  6 PC_BOUND_CHECK_EN, IMEM_DEPTH=64: jump imm=64 -> fault=1, pc unchanged; without macro ->
//    pc=64; pc=63 sequential -> fault with macro, pc=64 without.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state and next-PC select encodings for pc_sequencer
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } pc_state_t;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_JMP = 2'd2,
        SEL_JR  = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC target mux and bound compare (PC_BOUND_CHECK_EN)
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter longint unsigned IMEM_DEPTH = 64
) (
    input  logic [PC_W-1:0] pc,
    input  logic            branch,
    input  logic            zero,
    input  logic            jump,
    input  logic            jr,
    input  logic [PC_W-1:0] imm,
    input  logic [PC_W-1:0] reg_target,
`ifdef PC_BOUND_CHECK_EN
    output logic            out_of_bound,
`endif
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] w_pc_inc;
    pc_sel_t         w_sel;

    assign w_pc_inc = pc + PC_W'(1);

    // Priority select: taken branch, then jr, then absolute jump, else sequential
    always_comb begin
        w_sel = SEL_SEQ;
        if (branch && zero)
            w_sel = SEL_BR;
        else if (jump && jr)
            w_sel = SEL_JR;
        else if (jump)
            w_sel = SEL_JMP;
    end

    // Target mux; sums wrap modulo 2**PC_W
    always_comb begin
        next_pc = w_pc_inc;
        case (w_sel)
            SEL_BR:  next_pc = w_pc_inc + imm;
            SEL_JR:  next_pc = reg_target;
            SEL_JMP: next_pc = imm;
            default: next_pc = w_pc_inc;
        endcase
    end

`ifdef PC_BOUND_CHECK_EN
    // Compare one bit wider so IMEM_DEPTH == 2**PC_W never flags
    localparam logic [PC_W:0] DEPTH_EXT = (PC_W+1)'(IMEM_DEPTH);
    assign out_of_bound = ({1'b0, next_pc} >= DEPTH_EXT);
`endif

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter, stall/halt FSM and retire counter; optional PC_BOUND_CHECK_EN
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter longint unsigned IMEM_DEPTH = 64,
    parameter int              CNT_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              branch,
    input  logic              zero,
    input  logic              jump,
    input  logic              jr,
    input  logic              hlt,
    input  logic              io_wait,
    input  logic              confirm,
    input  logic [PC_W-1:0]   imm,
    input  logic [PC_W-1:0]   reg_target,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   pc_plus_one,
    output logic              retire,
    output logic              halted,
    output logic              fault,
    output logic [CNT_W-1:0]  instret
);

    pc_state_t        r_state;
    pc_state_t        w_next_state;
    logic             r_conf_q;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_instret;
    logic [PC_W-1:0]  w_next_pc;
    logic             w_rise;
    logic             w_advance;
    logic             w_load;
    logic             w_retire;
`ifdef PC_BOUND_CHECK_EN
    logic             w_oob;
`endif

    pc_next_sel #(
        .PC_W       (PC_W),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_next_sel (
        .pc           (r_pc),
        .branch       (branch),
        .zero         (zero),
        .jump         (jump),
        .jr           (jr),
        .imm          (imm),
        .reg_target   (reg_target),
`ifdef PC_BOUND_CHECK_EN
        .out_of_bound (w_oob),
`endif
        .next_pc      (w_next_pc)
    );

    assign w_rise = confirm & ~r_conf_q;

    // Next state, PC load enable and retire; HALT/FAULT ignore all inputs
    always_comb begin
        w_next_state = r_state;
        w_advance    = 1'b0;
        w_load       = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (hlt) begin
                    w_next_state = ST_HALT;
                    w_retire     = 1'b1;
                end else if (io_wait && !w_rise) begin
                    w_next_state = ST_WAIT;
                end else begin
                    w_advance = 1'b1;
                end
            end
            ST_WAIT: begin
                if (w_rise)
                    w_advance = 1'b1;
            end
            default: begin
                w_next_state = r_state;
            end
        endcase
        if (w_advance) begin
`ifdef PC_BOUND_CHECK_EN
            if (w_oob) begin
                w_next_state = ST_FAULT;
            end else begin
                w_next_state = ST_RUN;
                w_load       = 1'b1;
                w_retire     = 1'b1;
            end
`else
            w_next_state = ST_RUN;
            w_load       = 1'b1;
            w_retire     = 1'b1;
`endif
        end
    end

    // State, confirm history, PC and retired count; reset overrides everything
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_conf_q  <= 1'b0;
            r_pc      <= RESET_PC;
            r_instret <= '0;
        end else begin
            r_state   <= w_next_state;
            r_conf_q  <= confirm;
            if (w_load)
                r_pc <= w_next_pc;
            r_instret <= r_instret + CNT_W'(w_retire);
        end
    end

    assign pc          = r_pc;
    assign pc_plus_one = r_pc + PC_W'(1);
    assign retire      = w_retire;
    assign halted      = (r_state == ST_HALT);
    assign instret     = r_instret;
`ifdef PC_BOUND_CHECK_EN
    assign fault       = (r_state == ST_FAULT);
`else
    assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer (honours PC_BOUND_CHECK_EN)
module tb_pc_sequencer;

    localparam int DEPTH = 64;

    logic        clock;
    logic        reset;
    logic        branch, zero, jump, jr, hlt, io_wait, confirm;
    logic [31:0] imm, reg_target;
    logic [31:0] pc, pc_plus_one, instret;
    logic        retire, halted, fault;

    pc_sequencer #(
        .PC_W       (32),
        .IMEM_DEPTH (DEPTH),
        .CNT_W      (32),
        .RESET_PC   (32'd0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .jr          (jr),
        .hlt         (hlt),
        .io_wait     (io_wait),
        .confirm     (confirm),
        .imm         (imm),
        .reg_target  (reg_target),
        .pc          (pc),
        .pc_plus_one (pc_plus_one),
        .retire      (retire),
        .halted      (halted),
        .fault       (fault),
        .instret     (instret)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        ret;
        logic        hl;
        logic        flt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // reference model: simple status flags and 32-bit wrapping arithmetic
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_stopped, m_faulted, m_waiting, m_confq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // monitor: every cycle with an expectation outstanding is checked mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", pc, e.pc);
                chk("pc_plus_one", pc_plus_one, e.pc + 32'd1);
                chk("retire", {31'd0, retire}, {31'd0, e.ret});
                chk("halted", {31'd0, halted}, {31'd0, e.hl});
                chk("fault", {31'd0, fault}, {31'd0, e.flt});
                chk("instret", instret, e.cnt);
            end
        end
    end

    task automatic step(input bit rst, input bit br, input bit z, input bit j, input bit r,
                        input bit h, input bit w, input bit c,
                        input logic [31:0] im, input logic [31:0] rt);
        exp_t        e;
        bit          rise, adv, ret;
        logic [31:0] tgt;
        reset = rst; branch = br; zero = z; jump = j; jr = r;
        hlt = h; io_wait = w; confirm = c; imm = im; reg_target = rt;
        if (rst) begin
            m_pc = 32'd0; m_cnt = 32'd0;
            m_stopped = 0; m_faulted = 0; m_waiting = 0; m_confq = 0;
        end else begin
            rise = c && !m_confq;
            adv  = 0;
            ret  = 0;
            if (m_stopped || m_faulted) begin
                adv = 0;
            end else if (m_waiting) begin
                adv = rise;
            end else if (h) begin
                ret = 1;
            end else if (w && !rise) begin
                adv = 0;
            end else begin
                adv = 1;
            end
            if (br && z)     tgt = m_pc + 32'd1 + im;
            else if (j && r) tgt = rt;
            else if (j)      tgt = im;
            else             tgt = m_pc + 32'd1;
            e.pc  = m_pc;
            e.cnt = m_cnt;
            e.hl  = m_stopped;
            e.flt = m_faulted;
`ifdef PC_BOUND_CHECK_EN
            if (adv && tgt >= 32'(DEPTH)) begin
                m_faulted = 1;
                adv = 0;
            end
`endif
            if (adv) ret = 1;
            e.ret = ret;
            exp_q.push_back(e);
            if (!m_stopped && !m_faulted) begin
                if (h && !m_waiting) m_stopped = 1;
                else if (adv) begin m_pc = tgt; m_waiting = 0; end
                else if (!m_waiting && w) m_waiting = 1;
            end
            m_cnt  = m_cnt + 32'(ret);
            m_confq = c;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input bit c);
        step(0, 0, 0, 0, 0, 0, 0, c, 32'd0, 32'd0);
    endtask

    initial begin
        reset = 1; branch = 0; zero = 0; jump = 0; jr = 0; hlt = 0;
        io_wait = 0; confirm = 0; imm = 0; reg_target = 0;
        m_pc = 0; m_cnt = 0; m_stopped = 0; m_faulted = 0; m_waiting = 0; m_confq = 0;
        @(posedge clock); #1;

        // sequential run after reset
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) idle(0);

        // branch arithmetic and priority
        step(0, 0, 0, 1, 0, 0, 0, 0, 32'd10, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0, -32'sd3, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, -32'sd3, 0);
        step(0, 1, 1, 1, 0, 0, 0, 0, -32'sd3, 0);

        // jr versus absolute jump
        step(0, 0, 0, 1, 0, 0, 0, 0, 32'd4, 0);
        step(0, 0, 0, 1, 1, 0, 0, 0, 32'd9, 32'd20);
        step(0, 0, 0, 1, 0, 0, 0, 0, 32'd7, 32'd20);

        // io_wait with confirm already high must stall until a fresh edge
        idle(1);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        idle(1);
        idle(0);

        // halt at pc 9, frozen, then reset out of it
        step(0, 0, 0, 1, 0, 0, 0, 0, 32'd9, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            step(0, 1, 1, 1, 0, 1, 1, i[0], 32'd3, 32'd5);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);

        // boundary targets past the instruction memory
        step(0, 0, 0, 1, 0, 0, 0, 0, 32'd64, 0);
        idle(0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 32'd63, 0);
        idle(0);
        idle(0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 32'd62, 0);
        idle(0);
        idle(0);

        // randomized traffic with occasional resets
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            bit          rr, bb, zz, jj, rj, hh, ww, cc;
            logic [31:0] ii, tt;
            rr = ($urandom_range(99) < 3);
            bb = ($urandom_range(99) < 20);
            zz = $urandom_range(1);
            jj = ($urandom_range(99) < 15);
            rj = $urandom_range(1);
            hh = ($urandom_range(99) < 2);
            ww = ($urandom_range(99) < 15);
            cc = ($urandom_range(99) < 40);
            ii = $urandom_range(1) ? 32'($urandom_range(70)) : 32'($signed($urandom_range(16)) - 8);
            tt = 32'($urandom_range(70));
            step(rr, bb, zz, jj, rj, hh, ww, cc, ii, tt);
        end

        idle(0);
        @(negedge clock);
        @(negedge clock);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
